mem_stage: RTL and testbench
============================

# mem_stage

MEM pipeline stage of the AZPR CPU. It sits directly downstream of the EX stage and consumes the EX/MEM pipeline register. It executes LDW/STW against either the scratch-pad memory (single-cycle, direct port) or the shared system bus (request/grant/strobe/ready handshake), and detects misaligned accesses. It produces the MEM/WB pipeline register plus a forwarding value and a `busy` stall request for the pipeline controller.

## Interface
Parameters:
- `SPM_SEL`, 3'b011: value of word-address bits [29:27] that selects the SPM.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `stall` in 1: pipeline stall; holds the MEM/WB register and the WAIT state.
- `flush` in 1: pipeline flush.
- `busy` out 1: stall request; asserted while a bus access is outstanding.
- `fwd_data` out 32: forwarding data, equal to the stage result `out`.
- `spm_rd_data` in 32: SPM read data (combinational).
- `spm_addr` out 30: SPM word address.
- `spm_as_` out 1: SPM address strobe, active-low.
- `spm_rw` out 1: SPM direction; 1 = READ, 0 = WRITE.
- `spm_wr_data` out 32: SPM write data.
- `bus_rd_data` in 32: bus read data.
- `bus_rdy_` in 1: bus ready, active-low.
- `bus_grnt_` in 1: bus grant, active-low.
- `bus_req_` out 1: bus request, active-low.
- `bus_addr` out 30: bus word address.
- `bus_as_` out 1: bus address strobe, active-low.
- `bus_rw` out 1: bus direction; 1 = READ, 0 = WRITE.
- `bus_wr_data` out 32: bus write data.
- `ex_pc` in 30, `ex_en` in 1, `ex_br_flag` in 1, `ex_mem_op` in 2, `ex_mem_wr_data` in 32, `ex_ctrl_op` in 2, `ex_dst_addr` in 5, `ex_gpr_we_` in 1, `ex_exp_code` in 3, `ex_out` in 32: EX/MEM pipeline register.
- `mem_pc` out 30, `mem_en` out 1, `mem_br_flag` out 1, `mem_ctrl_op` out 2, `mem_dst_addr` out 5, `mem_gpr_we_` out 1, `mem_exp_code` out 3, `mem_out` out 32: MEM/WB pipeline register.

## Operation
Memory controller (combinational):
- Memory ops: NOP = 0, LDW = 1, STW = 2.
- Access address `addr` = `ex_out[31:2]`.
- When `ex_en` = 1 and the op is LDW/STW:
  - `ex_out[1:0]` = 0: `as_` = 0, with `rw` = READ for LDW and WRITE for STW.
  - `ex_out[1:0]` ≠ 0: `miss_align` = 1 and `as_` stays 1.
- When `ex_en` = 0 or the op is NOP: `as_` = 1.
- `out` = loaded data for LDW with no misalignment; otherwise `out` = `ex_out`.

Bus interface FSM, states IDLE, REQ, ACCESS, WAIT:
- IDLE, with `as_` = 0 and `flush` = 0:
  - SPM hit (`addr[29:27]` = `SPM_SEL`):
    - Drive `spm_as_` = 0 combinationally.
    - Read data = `spm_rd_data`.
    - `busy` = 0; stay in IDLE.
  - Otherwise:
    - `busy` = 1, `bus_req_` <= 0, go to REQ.
- REQ: `busy` = 1. When `bus_grnt_` = 0:
  - `bus_as_` <= 0; latch `bus_addr`, `bus_rw`, `bus_wr_data`; go to ACCESS.
- ACCESS: `busy` = 1; `bus_as_` <= 1 (strobe lasts exactly one cycle). When `bus_rdy_` = 0:
  - `bus_req_` <= 1.
  - On READ, latch `bus_rd_data` into `rd_buf`.
  - Go to WAIT.
- WAIT: `busy` = 0; read data = `rd_buf`. Leave for IDLE when `stall` = 0.
- `flush` in IDLE suppresses starting any access. `flush` in REQ, ACCESS or WAIT does not abort a started bus transaction.

MEM/WB register:
- Updates only when `stall` = 0.
- `flush`: clear the register to the reset values.
- Else `miss_align`:
  - `mem_exp_code` <= 4 (MISS_ALIGN).
  - `mem_gpr_we_` <= 1; `mem_ctrl_op` <= NOP; `mem_out` <= 0.
  - Other fields pass through.
- Else: all `ex_*` fields pass through and `mem_out` <= `out`.

## Timing
- Reset values, all outputs and state:
  - `mem_*` = 0, except `mem_gpr_we_` = 1.
  - `bus_req_` = 1, `bus_as_` = 1, `bus_rw` = READ, `bus_addr` = 0, `bus_wr_data` = 0.
  - `rd_buf` = 0; FSM in IDLE.
  - `busy` = 0 and `spm_as_` = 1 follow from IDLE with `ex_en` = 0.
- Reset during REQ/ACCESS returns to IDLE immediately and releases the bus.
- SPM access: zero added latency; the result enters the MEM/WB register at the next edge.
- Bus access: minimum 3 busy cycles (REQ → grant, ACCESS → ready, then WAIT with `busy` = 0).
  - The pipeline controller holds `stall` while `busy` = 1.
  - In WAIT, `stall` = 0 is required for the result to be registered.
- `busy`, `out` and `fwd_data` are combinational from the FSM state and the inputs.
- `bus_rdy_` sampled outside ACCESS is ignored.
- `bus_grnt_` sampled outside REQ is ignored.

## Test plan
- SPM LDW, `ex_out` = 0x6000_0010, `spm_rd_data` = 0xCAFEBABE → `spm_as_` = 0, `spm_addr` = 0x1800_0004, `busy` = 0; next edge `mem_out` = 0xCAFEBABE.
- Bus STW, `ex_out` = 0x0000_0100, wr data 0x12345678, grant after 2 cycles, ready after 1 → `bus_as_` low exactly 1 cycle, `bus_addr` = 0x40, `bus_rw` = 0; `busy` high 4 cycles; `bus_req_` released after ready.
- LDW, `ex_out` = 0x0000_0102 → no strobe on either port; `mem_exp_code` = 4, `mem_gpr_we_` = 1.
- Bus LDW reaches WAIT with `stall` held 3 extra cycles → `mem_out` unchanged until `stall` drops; then `mem_out` = latched `bus_rd_data`; FSM back to IDLE.
- `flush` = 1 in IDLE with valid LDW → no request issued; `mem_en` = 0, `mem_gpr_we_` = 1.
- `reset` asserted in ACCESS → `bus_req_` = 1, `bus_as_` = 1 and `busy` = 0 without a clock edge.

Source files
------------

// File: rtl/mem_stage.sv
// AZPR MEM stage: executes LDW/STW against the scratch-pad memory or the shared bus,
// detects misaligned accesses and produces the MEM/WB pipeline register.
module mem_stage #(
    parameter logic [2:0] SPM_SEL = 3'b011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] fwd_data,
    input  logic [31:0] spm_rd_data,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    input  logic        bus_grnt_,
    output logic        bus_req_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] MEM_OP_NOP     = 2'd0;
    localparam logic [1:0] MEM_OP_LDW     = 2'd1;
    localparam logic [1:0] MEM_OP_STW     = 2'd2;
    localparam logic       RW_READ        = 1'b1;
    localparam logic       RW_WRITE       = 1'b0;
    localparam logic [1:0] CTRL_OP_NOP    = 2'd0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_WAIT} state_t;

    state_t      state;
    logic [31:0] rd_buf;
    logic [29:0] addr;
    logic        mem_access;
    logic        as_;
    logic        rw;
    logic        miss_align;
    logic        spm_hit;
    logic        start;
    logic [31:0] rd_data;
    logic [31:0] out;

    // Memory controller: strobe generation and alignment check
    always_comb begin
        addr       = ex_out[31:2];
        mem_access = ex_en && ((ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW));
        as_        = !(mem_access && (ex_out[1:0] == 2'b00));
        miss_align = mem_access && (ex_out[1:0] != 2'b00);
        rw         = (ex_mem_op == MEM_OP_STW) ? RW_WRITE : RW_READ;
        spm_hit    = (addr[29:27] == SPM_SEL);
        start      = (state == ST_IDLE) && !as_ && !flush;
    end

    // Read-data source, stall request and stage result
    always_comb begin
        rd_data = '0;
        busy    = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_data = spm_rd_data;
                busy    = start && !spm_hit;
            end
            ST_REQ, ST_ACCESS: busy = 1'b1;
            ST_WAIT: rd_data = rd_buf;
            default: begin
                rd_data = '0;
                busy    = 1'b0;
            end
        endcase
        out = (ex_en && (ex_mem_op == MEM_OP_LDW) && !miss_align) ? rd_data : ex_out;
    end

    assign fwd_data    = out;
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = ex_mem_wr_data;
    assign spm_as_     = !(start && spm_hit);

    // Bus handshake FSM; a started transaction always runs to completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= RW_READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !spm_hit) begin
                        bus_req_ <= 1'b0;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus_grnt_) begin
                        bus_as_     <= 1'b0;
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= ex_mem_wr_data;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        bus_req_ <= 1'b1;
                        if (bus_rw == RW_READ) begin
                            rd_buf <= bus_rd_data;
                        end
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB pipeline register; misaligned accesses become an exception bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= CTRL_OP_NOP;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= '0;
            mem_out      <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_pc       <= '0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= CTRL_OP_NOP;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= '0;
                mem_out      <= '0;
            end else if (miss_align) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= CTRL_OP_NOP;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_MISS_ALIGN;
                mem_out      <= '0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle SPM/alignment/flush cases plus
// hand-written bus transaction, WAIT-stall and reset-abort sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [31:0] fwd_data;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grnt_;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [29:0] ex_pc;
    logic        ex_en;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .fwd_data(fwd_data), .spm_rd_data(spm_rd_data), .spm_addr(spm_addr),
        .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
        .ex_out(ex_out), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
        .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] eout;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic        fl;
        logic        we_in;
        logic [2:0]  exp_in;
        logic        x_spm_as;
        logic        x_busy;
        logic        x_en;
        logic        x_we;
        logic [2:0]  x_exp;
        logic [31:0] x_out;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] eout,
                          input logic [31:0] wdata, input logic we_in, input logic [2:0] exp_in);
        ex_en          = en;
        ex_mem_op      = op;
        ex_out         = eout;
        ex_mem_wr_data = wdata;
        ex_gpr_we_     = we_in;
        ex_exp_code    = exp_in;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:4] s_grnt, s_rdy, s_stall, x_busy, x_as, x_req;
        logic [0:6] l_grnt, l_rdy, l_stall, l_busy;
        int busy_cnt;

        // en op eout wdata sdata fl we exp | spm_as busy en we exp out
        vecs[0] = '{1'b1, 2'd1, 32'h6000_0010, 32'h0, 32'hCAFE_BABE, 1'b0, 1'b0, 3'd0,
                    1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'hCAFE_BABE};
        vecs[1] = '{1'b1, 2'd2, 32'h6000_0020, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 1'b1, 3'd0,
                    1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h6000_0020};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_0102, 32'h0, 32'h2222_2222, 1'b0, 1'b0, 3'd0,
                    1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 32'h6000_0003, 32'h7777_7777, 32'h0, 1'b0, 1'b1, 3'd0,
                    1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 32'h0};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h4444_4444, 1'b0, 1'b0, 3'd1,
                    1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_1234};
        vecs[5] = '{1'b0, 2'd1, 32'h0000_0200, 32'h0, 32'h5555_5555, 1'b0, 1'b1, 3'd0,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_0200};
        vecs[6] = '{1'b1, 2'd1, 32'h0000_0100, 32'h0, 32'h6666_6666, 1'b1, 1'b0, 3'd2,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0};
        vecs[7] = '{1'b1, 2'd1, 32'h6000_0010, 32'h0, 32'h3333_3333, 1'b1, 1'b0, 3'd0,
                    1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0};

        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        spm_rd_data = '0; bus_rd_data = '0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        ex_pc = 30'h0000_0123; ex_br_flag = 1'b0; ex_ctrl_op = 2'd0; ex_dst_addr = 5'd3;
        set_ex(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 3'd0);

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst mem_out", mem_out, 32'h0);
        chk("rst mem_gpr_we_", 32'(mem_gpr_we_), 32'h1);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst bus_req_", 32'(bus_req_), 32'h1);
        chk("rst bus_as_", 32'(bus_as_), 32'h1);
        chk("rst bus_rw", 32'(bus_rw), 32'h1);
        chk("rst bus_addr", 32'(bus_addr), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst spm_as_", 32'(spm_as_), 32'h1);
        reset = 1'b1;
        next_cycle();

        // Single-cycle table
        for (int i = 0; i < 8; i++) begin
            set_ex(vecs[i].en, vecs[i].op, vecs[i].eout, vecs[i].wdata, vecs[i].we_in, vecs[i].exp_in);
            spm_rd_data = vecs[i].sdata;
            flush = vecs[i].fl;
            @(negedge clk);
            chk($sformatf("v%0d spm_as_", i), 32'(spm_as_), 32'(vecs[i].x_spm_as));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].x_busy));
            chk($sformatf("v%0d spm_addr", i), 32'(spm_addr), 32'(vecs[i].eout[31:2]));
            next_cycle();
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].x_en));
            chk($sformatf("v%0d mem_gpr_we_", i), 32'(mem_gpr_we_), 32'(vecs[i].x_we));
            chk($sformatf("v%0d mem_exp_code", i), 32'(mem_exp_code), 32'(vecs[i].x_exp));
            chk($sformatf("v%0d mem_out", i), mem_out, vecs[i].x_out);
            chk($sformatf("v%0d bus_req_", i), 32'(bus_req_), 32'h1);
        end
        flush = 1'b0;
        chk("spm ldw spm_addr const", 32'(vecs[0].eout[31:2]), 32'h1800_0004);

        // Bus STW: grant after 2 cycles, ready after 1; stray ready in REQ must be ignored
        s_grnt = 5'b11011; s_rdy = 5'b10101; s_stall = 5'b11110;
        x_busy = 5'b11110; x_as = 5'b11101; x_req = 5'b10001;
        busy_cnt = 0;
        set_ex(1'b1, 2'd2, 32'h0000_0100, 32'h1234_5678, 1'b1, 3'd0);
        for (int c = 0; c < 5; c++) begin
            bus_grnt_ = s_grnt[c];
            bus_rdy_  = s_rdy[c];
            stall     = s_stall[c];
            @(negedge clk);
            if (busy) busy_cnt++;
            chk($sformatf("stw c%0d busy", c), 32'(busy), 32'(x_busy[c]));
            chk($sformatf("stw c%0d bus_as_", c), 32'(bus_as_), 32'(x_as[c]));
            chk($sformatf("stw c%0d bus_req_", c), 32'(bus_req_), 32'(x_req[c]));
            chk($sformatf("stw c%0d spm_as_", c), 32'(spm_as_), 32'h1);
            if (c == 3) begin
                chk("stw bus_addr", 32'(bus_addr), 32'h40);
                chk("stw bus_rw", 32'(bus_rw), 32'h0);
                chk("stw bus_wr_data", bus_wr_data, 32'h1234_5678);
            end
            next_cycle();
        end
        chk("stw busy cycles", 32'(busy_cnt), 32'd4);
        chk("stw mem_out", mem_out, 32'h0000_0100);
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        set_ex(1'b0, 2'd0, 32'h0000_0055, 32'h0, 1'b1, 3'd0);
        #1;
        chk("stw idle busy", 32'(busy), 32'h0);
        chk("stw idle bus_req_", 32'(bus_req_), 32'h1);
        next_cycle();
        chk("idle mem_out", mem_out, 32'h0000_0055);

        // Bus LDW held in WAIT for 3 extra stalled cycles
        l_grnt = 7'b1011111; l_rdy = 7'b1101111; l_stall = 7'b1111110; l_busy = 7'b1110000;
        set_ex(1'b1, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 3'd0);
        for (int c = 0; c < 7; c++) begin
            bus_grnt_   = l_grnt[c];
            bus_rdy_    = l_rdy[c];
            stall       = l_stall[c];
            bus_rd_data = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            chk($sformatf("ldw c%0d busy", c), 32'(busy), 32'(l_busy[c]));
            if (c == 2) begin
                chk("ldw bus_as_", 32'(bus_as_), 32'h0);
                chk("ldw bus_rw", 32'(bus_rw), 32'h1);
                chk("ldw bus_addr", 32'(bus_addr), 32'h80);
            end
            if (c >= 3) begin
                chk($sformatf("ldw c%0d mem_out held", c), mem_out, 32'h0000_0055);
                chk($sformatf("ldw c%0d fwd_data", c), fwd_data, 32'hDEAD_BEEF);
            end
            next_cycle();
        end
        chk("ldw mem_out", mem_out, 32'hDEAD_BEEF);
        chk("ldw mem_gpr_we_", 32'(mem_gpr_we_), 32'h0);
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        set_ex(1'b1, 2'd1, 32'h6000_0040, 32'h0, 1'b0, 3'd0);
        spm_rd_data = 32'h0BAD_F00D;
        #1;
        chk("post-wait spm_as_", 32'(spm_as_), 32'h0);
        chk("post-wait busy", 32'(busy), 32'h0);
        chk("post-wait fwd_data", fwd_data, 32'h0BAD_F00D);
        next_cycle();
        chk("post-wait mem_out", mem_out, 32'h0BAD_F00D);

        // Reset while the bus strobe is active
        set_ex(1'b1, 2'd1, 32'h0000_0300, 32'h0, 1'b0, 3'd0);
        stall = 1'b1; bus_grnt_ = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rstacc bus_as_ before", 32'(bus_as_), 32'h0);
        #1;
        reset = 1'b0;
        ex_en = 1'b0;
        #1;
        chk("rstacc bus_req_", 32'(bus_req_), 32'h1);
        chk("rstacc bus_as_", 32'(bus_as_), 32'h1);
        chk("rstacc busy", 32'(busy), 32'h0);
        next_cycle();
        reset = 1'b1; stall = 1'b0; bus_grnt_ = 1'b1;
        next_cycle();
        chk("rstacc after busy", 32'(busy), 32'h0);
        chk("rstacc after bus_req_", 32'(bus_req_), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
